// File: rtl/uart_rx_drain_ctrl.sv
// Receiver FIFO drain sequencer: pops records in bursts, presents them as a valid/ready
// byte stream and raises the receive-data, character-timeout and line-status interrupts.
module uart_rx_drain_ctrl #(
  parameter int FIFO_COUNTER_W = 5,
  parameter int REC_WIDTH      = 11
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic                      enable,
  input  logic [1:0]                trig_lvl,
  input  logic [FIFO_COUNTER_W-1:0] rf_count,
  input  logic [REC_WIDTH-1:0]      rf_data_out,
  input  logic                      rf_overrun,
  input  logic [9:0]                counter_t,
  input  logic                      rx_reset,
  input  logic                      lsr_clr,
  output logic                      rf_pop,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [7:0]                m_data,
  output logic [2:0]                m_err,
  output logic                      rda_int,
  output logic                      ti_int,
  output logic                      ls_int,
  output logic [3:0]                err_flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [FIFO_COUNTER_W-1:0] CNT_ZERO = {FIFO_COUNTER_W{1'b0}};

  state_t                    state_q;
  logic [FIFO_COUNTER_W-1:0] burst_left_q;
  logic [FIFO_COUNTER_W-1:0] trig;
  logic                      rf_pop_q;
  logic                      m_valid_q;
  logic [7:0]                m_data_q;
  logic [2:0]                m_err_q;
  logic                      rda_int_q;
  logic                      ti_int_q;
  logic [3:0]                err_flags_q;
  logic [2:0]                load_err;

  always_comb begin
    case (trig_lvl)
      2'b00:   trig = FIFO_COUNTER_W'(1);
      2'b01:   trig = FIFO_COUNTER_W'(4);
      2'b10:   trig = FIFO_COUNTER_W'(8);
      2'b11:   trig = FIFO_COUNTER_W'(14);
      default: trig = FIFO_COUNTER_W'(1);
    endcase
  end

  // Error bits of a record popped this cycle; a record dropped by rx_reset does not count.
  always_comb begin
    if ((state_q == LOAD) && !rx_reset) begin
      load_err = rf_data_out[2:0];
    end else begin
      load_err = 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      burst_left_q <= CNT_ZERO;
      rf_pop_q     <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= 8'h00;
      m_err_q      <= 3'b000;
      rda_int_q    <= 1'b0;
      ti_int_q     <= 1'b0;
      err_flags_q  <= 4'b0000;
    end else begin
      rda_int_q   <= (rf_count >= trig);
      ti_int_q    <= (counter_t == 10'd0) && (rf_count != CNT_ZERO) && (state_q == IDLE);
      // New error events win over a simultaneous LSR clear.
      err_flags_q <= (lsr_clr ? 4'b0000 : err_flags_q) | {rf_overrun, load_err};
      rf_pop_q    <= 1'b0;
      if (rx_reset) begin
        state_q      <= IDLE;
        m_valid_q    <= 1'b0;
        burst_left_q <= CNT_ZERO;
      end else begin
        case (state_q)
          IDLE: begin
            if (enable && (rf_count >= trig)) begin
              burst_left_q <= trig;
              rf_pop_q     <= 1'b1;
              state_q      <= LOAD;
            end else if (enable && (counter_t == 10'd0) && (rf_count != CNT_ZERO)) begin
              burst_left_q <= rf_count;
              rf_pop_q     <= 1'b1;
              state_q      <= LOAD;
            end else begin
              state_q <= IDLE;
            end
          end
          LOAD: begin
            m_data_q  <= rf_data_out[10:3];
            m_err_q   <= rf_data_out[2:0];
            m_valid_q <= 1'b1;
            if (burst_left_q != CNT_ZERO) begin
              burst_left_q <= burst_left_q - FIFO_COUNTER_W'(1);
            end else begin
              burst_left_q <= CNT_ZERO;
            end
            state_q <= SEND;
          end
          SEND: begin
            if (m_valid_q && m_ready) begin
              m_valid_q <= 1'b0;
              if ((burst_left_q != CNT_ZERO) && (rf_count != CNT_ZERO) && enable) begin
                rf_pop_q <= 1'b1;
                state_q  <= LOAD;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              state_q <= SEND;
            end
          end
          default: begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rf_pop    = rf_pop_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_err     = m_err_q;
  assign rda_int   = rda_int_q;
  assign ti_int    = ti_int_q;
  assign err_flags = err_flags_q;
  assign ls_int    = |err_flags_q;

endmodule
